// File: rtl/fft8_bin_serializer.sv
// fft8_bin_serializer: captures an 8-bin complex FFT frame in one handshake and
// streams the bins out one per cycle with a valid/ready handshake.
// Optional feature macro: MAG_SQ_EN adds out_mag = re^2 + im^2 per bin.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   frame handshake; in_re/in_im carry bin k at [k*DW +: DW]
//   out_valid/out_ready bin handshake; out_re/out_im bin value (signed Q8.8)
//   out_idx             bin index 0..7, out_last marks bin 7
//   out_mag             squared magnitude, unsigned Q17.16 (MAG_SQ_EN only)
// in_ready is combinational (depends on out_ready); all other outputs are registered.
module fft8_bin_serializer #(
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_re,
  input  logic [8*DW-1:0] in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [2:0]      out_idx,
`ifdef MAG_SQ_EN
  output logic [2*DW:0]   out_mag,
`endif
  output logic            out_last
);

  localparam int unsigned NB = 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [2:0]      idx_nxt;
  logic [DW-1:0]   buf_re [NB];
  logic [DW-1:0]   buf_im [NB];
  logic            accept;
  logic            advance;

`ifdef MAG_SQ_EN
  // Full-precision signed squares; both are non-negative so zero-extension is exact.
  function automatic logic [2*DW:0] mag_sq(input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic signed [2*DW-1:0] pr;
    logic signed [2*DW-1:0] pi;
    pr = $signed(re) * $signed(re);
    pi = $signed(im) * $signed(im);
    return (2*DW+1)'($unsigned(pr)) + (2*DW+1)'($unsigned(pi));
  endfunction
`endif

  // Accept a new frame when idle, or back-to-back as bin 7 leaves.
  assign in_ready = (state == IDLE) || ((state == SEND) && (idx == 3'd7) && out_ready);
  assign accept   = in_valid && in_ready;
  assign advance  = (state == SEND) && out_ready;
  assign idx_nxt  = idx + 3'd1;

  // FSM, frame buffer and registered bin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
`ifdef MAG_SQ_EN
      out_mag   <= '0;
`endif
      for (int k = 0; k < NB; k++) begin
        buf_re[k] <= '0;
        buf_im[k] <= '0;
      end
    end else if (accept) begin
      // Bin 0 is presented straight from the input so it shows the next cycle.
      for (int k = 0; k < NB; k++) begin
        buf_re[k] <= in_re[k*DW +: DW];
        buf_im[k] <= in_im[k*DW +: DW];
      end
      state     <= SEND;
      idx       <= 3'd0;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      out_re    <= in_re[DW-1:0];
      out_im    <= in_im[DW-1:0];
      out_idx   <= 3'd0;
`ifdef MAG_SQ_EN
      out_mag   <= mag_sq(in_re[DW-1:0], in_im[DW-1:0]);
`endif
    end else if (advance) begin
      if (idx == 3'd7) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        idx      <= idx_nxt;
        out_re   <= buf_re[idx_nxt];
        out_im   <= buf_im[idx_nxt];
        out_idx  <= idx_nxt;
        out_last <= (idx_nxt == 3'd7);
`ifdef MAG_SQ_EN
        out_mag  <= mag_sq(buf_re[idx_nxt], buf_im[idx_nxt]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_fft8_bin_serializer.sv
// Self-checking bench for fft8_bin_serializer: directed and random frames
// compared against a queue-based model of the expected bin stream.
module tb_fft8_bin_serializer;

  localparam int unsigned DW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] in_re;
  logic [8*DW-1:0] in_im;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_re;
  logic [DW-1:0]   out_im;
  logic [2:0]      out_idx;
  logic            out_last;
`ifdef MAG_SQ_EN
  logic [2*DW:0]   out_mag;
`endif

  fft8_bin_serializer #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
`ifdef MAG_SQ_EN
    .out_mag  (out_mag),
`endif
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [2:0]    idx;
  } beat_t;

  beat_t           exp_q[$];
  logic [8*DW-1:0] send_re[$];
  logic [8*DW-1:0] send_im[$];
  int              checks = 0;
  int              errors = 0;
  int              mode   = 0;
  int              cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic add_frame(input logic [8*DW-1:0] r, input logic [8*DW-1:0] i);
    send_re.push_back(r);
    send_im.push_back(i);
  endtask

  function automatic logic [8*DW-1:0] rand_frame();
    logic [8*DW-1:0] f;
    for (int k = 0; k < 8; k++) f[k*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  // Drive the next cycle's inputs; idle input data is random garbage.
  task automatic drive_inputs();
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    in_valid = (send_re.size() != 0) && (mode != 2 || $urandom_range(0, 3) != 0);
    if (send_re.size() != 0) begin
      in_re = send_re[0];
      in_im = send_im[0];
    end else begin
      in_re = rand_frame();
      in_im = rand_frame();
    end
  endtask

  // One clock: check outputs against the model head, then advance the model.
  task automatic cycle();
    bit    exp_rdy;
    bit    acc;
    bit    pop;
    beat_t h;
    beat_t b;
    logic [8*DW-1:0] fr;
    logic [8*DW-1:0] fi;
    longint sr;
    longint si;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("out_re", 64'(out_re), 64'(h.re));
      chk("out_im", 64'(out_im), 64'(h.im));
      chk("out_idx", 64'(out_idx), 64'(h.idx));
      chk("out_last", 64'(out_last), 64'(h.idx == 3'd7));
`ifdef MAG_SQ_EN
      sr = longint'($signed(h.re));
      si = longint'($signed(h.im));
      chk("out_mag", 64'(out_mag), 64'(sr * sr + si * si));
      if (h.re == 16'h0100 && h.im == 16'hFF00) chk("mag_one_minus_one", 64'(out_mag), 64'h20000);
      if (h.re == 16'h8000 && h.im == 16'h8000) chk("mag_most_negative", 64'(out_mag), 64'h80000000);
`endif
    end
    acc = in_valid && exp_rdy;
    pop = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    cyc++;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      fr = send_re.pop_front();
      fi = send_im.pop_front();
      for (int k = 0; k < 8; k++) begin
        b.re  = fr[k*DW +: DW];
        b.im  = fi[k*DW +: DW];
        b.idx = 3'(k);
        exp_q.push_back(b);
      end
    end
    #1;
    drive_inputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((send_re.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (send_re.size() != 0 || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d frames and %0d bins still pending", tag, send_re.size(), exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_out_re"}, 64'(out_re), 64'd0);
    chk({tag, "_out_im"}, 64'(out_im), 64'd0);
    chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
`ifdef MAG_SQ_EN
    chk({tag, "_out_mag"}, 64'(out_mag), 64'd0);
`endif
  endtask

  logic [8*DW-1:0] ramp_re;
  logic [8*DW-1:0] ramp_im;
  logic [8*DW-1:0] mag_re;
  logic [8*DW-1:0] mag_im;
  int              guard;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ramp_re[k*DW +: DW] = DW'(k * 256);
      ramp_im[k*DW +: DW] = DW'(-k * 256);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_inputs();

    // Single ramp frame, always ready, then idle
    mode = 0;
    add_frame(ramp_re, ramp_im);
    drive_inputs();
    drain("ramp", 100);
    run_cycles(3);

    // Same frame with out_ready stalling 1,0,0,...
    mode = 1;
    add_frame(ramp_re, ramp_im);
    drive_inputs();
    drain("stall", 200);
    run_cycles(2);

    // Back-to-back frames; B is held on the inputs while A streams
    mode = 0;
    add_frame(rand_frame(), rand_frame());
    add_frame(rand_frame(), rand_frame());
    drive_inputs();
    drain("b2b", 100);
    run_cycles(2);

    // Random frames, random gaps and random backpressure
    mode = 2;
    for (int f = 0; f < 8; f++) add_frame(rand_frame(), rand_frame());
    drive_inputs();
    drain("random", 3000);
    run_cycles(2);

    // Reset while bin 3 is on the output
    mode = 0;
    add_frame(rand_frame(), rand_frame());
    add_frame(rand_frame(), rand_frame());
    drive_inputs();
    guard = 0;
    while (!(exp_q.size() == 5) && guard < 50) begin
      cycle();
      guard++;
    end
    chk("reached_idx3", 64'(exp_q.size()), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    send_re.delete();
    send_im.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_inputs();
    run_cycles(2);
    add_frame(ramp_re, ramp_im);
    drive_inputs();
    drain("after_reset", 100);

    // Magnitude corner bins: (1,-1) and (-128,-128)
    mag_re = rand_frame();
    mag_im = rand_frame();
    mag_re[0 +: DW]  = 16'h0100;
    mag_im[0 +: DW]  = 16'hFF00;
    mag_re[DW +: DW] = 16'h8000;
    mag_im[DW +: DW] = 16'h8000;
    add_frame(mag_re, mag_im);
    drive_inputs();
    drain("mag", 100);
    run_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft8_bin_serializer.md
FFT8_BIN_SERIALIZER -- requirements
Module: fft8_bin_serializer

Interface
REQ-001 Parameter DW, default 16, meaning: bin component width, signed Q8.8.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  a complete 8-bin frame is present on in_re/in_im.
REQ-005 in_ready  output  1  block accepts a frame this cycle.
REQ-006 in_re  input  8*DW  bin k real part at bits [k*DW +: DW], k=0..7.
REQ-007 in_im  input  8*DW  bin k imaginary part at bits [k*DW +: DW], k=0..7.
REQ-008 out_valid  output  1  out_re/out_im/out_idx/out_last hold a valid bin.
REQ-009 out_ready  input  1  downstream accepts the current bin.
REQ-010 out_re, out_im  output  DW each  current bin, signed Q8.8.
REQ-011 out_idx  output  3  index of the current bin, 0..7.
REQ-012 out_last  output  1  high when out_idx==7 and out_valid is high.
REQ-013 out_mag  output  2*DW+1  re^2+im^2 of the current bin, unsigned Q17.16; present only with MAG_SQ_EN.

Function
REQ-014 FSM states: IDLE and SEND.
REQ-015 IDLE: in_ready=1 and out_valid=0.
REQ-016 IDLE: in_valid=1 stores all 16 words in an internal frame buffer, sets idx=0 and moves to SEND on the same edge.
REQ-017 Latency: out_valid rises in the cycle after the accepting edge and shows bin 0.
REQ-018 SEND: out_valid=1, out_re=buf_re[idx], out_im=buf_im[idx], out_idx=idx.
REQ-019 SEND, out_ready=1, idx<7: idx increments by 1.
REQ-020 SEND, out_ready=0: idx and all outputs hold stable. The frame buffer does not change while out_valid=1 and out_ready=0.
REQ-021 in_ready = (state==IDLE) OR (state==SEND AND idx==7 AND out_ready).
REQ-022 In SEND, in_ready is 0 in every other case, and in_re/in_im are ignored.
REQ-023 idx==7, out_ready=1, in_valid=1: the new frame is captured, idx wraps to 0 and the FSM stays in SEND. There is no bubble between frames.
REQ-024 idx==7, out_ready=1, in_valid=0: the FSM returns to IDLE and out_valid=0 on the next cycle.
REQ-025 The frame buffer is written only on an in_valid AND in_ready edge.
REQ-026 Throughput: one bin per cycle while out_ready=1, which is 8 cycles per frame.

Reset
REQ-027 rst_n=0 forces, immediately and asynchronously:
- state=IDLE, idx=0
- out_valid=0, out_last=0
- out_re=0, out_im=0, out_idx=0, out_mag=0
- frame buffer cleared to 0
REQ-028 Reset during SEND discards the remaining bins. The first cycle after release is IDLE with in_ready=1.

Configuration
REQ-029 Macro: MAG_SQ_EN.
REQ-030 MAG_SQ_EN defined: out_mag = re*re + im*im, computed full-precision signed and zero-extended to 2*DW+1 bits. It is aligned with and holds together with out_re/out_im.
REQ-031 MAG_SQ_EN undefined: the out_mag port and its multipliers are absent, and all other behaviour is identical.

Verification
REQ-032 Reset, then one frame with bins re=k*256, im=-k*256 (k=0..7), in_valid held 1 cycle, out_ready=1:
- 8 consecutive beats, idx 0..7, matching values
- out_last only on beat 7
- IDLE afterwards
REQ-033 Same frame, out_ready toggled 1,0,0,1,... during SEND: no bin is lost or repeated, and the outputs are stable while stalled.
REQ-034 Two frames back-to-back (frame B presented at A's idx==7 with out_ready=1): 16 contiguous beats, B bin 0 directly after A bin 7, in_ready pulsed exactly at that edge.
REQ-035 in_valid=1 held during SEND with a different frame: that frame is not captured until in_ready=1, and the outputs of the current frame are unchanged.
REQ-036 rst_n pulsed low at idx==3:
- out_valid=0 immediately
- after release in_ready=1
- the next frame starts at idx 0
REQ-037 MAG_SQ_EN defined, bin re=0x0100, im=0xFF00 (1, -1): out_mag=0x20000 (2.0 in Q17.16). Bin re=0x8000, im=0x8000: out_mag=0x80000000.
